// File: rtl/mcycle_pkg.sv
// Shared definitions for the iterative multiply/divide unit: default width,
// operation encodings and controller states.
package mcycle_pkg;

  localparam int MC_WIDTH = 32;

  typedef enum logic [1:0] {
    MC_MULU = 2'b00,
    MC_MUL  = 2'b01,
    MC_DIVU = 2'b10,
    MC_DIV  = 2'b11
  } mcycle_op_e;

  typedef enum logic {
    MC_IDLE,
    MC_COMPUTE
  } mcycle_state_e;

endpackage

// File: rtl/mcycle_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface mcycle_if #(
  parameter int WIDTH = mcycle_pkg::MC_WIDTH
);

  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy, Done
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy, Done
  );

endinterface

// File: rtl/mcycle_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a
// double-width accumulator. For divide the new quotient bit is returned
// separately and the accumulator LSB is left clear.
module mcycle_step
  import mcycle_pkg::*;
#(
  parameter int WIDTH = MC_WIDTH
) (
  input  logic [2*WIDTH-1:0] accIn,
  input  logic [WIDTH-1:0]   operand,
  input  logic               isDiv,
  output logic [2*WIDTH-1:0] accOut,
  output logic               qBit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] diff;

  // The shifted remainder needs one extra bit before the trial subtract;
  // when it does not borrow the true difference always fits in WIDTH bits.
  always_comb begin
    sum      = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (accIn[0] ? {1'b0, operand} : '0);
    remShift = accIn[2*WIDTH-1:WIDTH-1];
    diff     = remShift[WIDTH-1:0] - operand;
    qBit     = 1'b0;
    accOut   = {sum, accIn[WIDTH-1:1]};
    if (isDiv) begin
      qBit   = (remShift >= {1'b0, operand});
      accOut = {(qBit ? diff : remShift[WIDTH-1:0]), accIn[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mcycle_unit.sv
// Iterative signed/unsigned 32x32 multiply and 32/32 divide. Works on
// magnitudes for WIDTH cycles, then applies sign correction on the last one.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = MC_WIDTH
) (
  input  logic     CLK,
  input  logic     RESETn,
  mcycle_if.slave  bus
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  mcycle_state_e      state, stateNext;
  mcycle_op_e         opIn;
  logic [CW-1:0]      count;
  logic               load, lastIter;
  logic               isDiv, negMain, negRem;
  logic               sign1, sign2, loadDiv;
  logic [WIDTH-1:0]   mag1, mag2, operand;
  logic [2*WIDTH-1:0] acc, stepAcc, iterAcc, prod;
  logic [WIDTH-1:0]   quot, rem, res1, res2;
  logic               qBit;

  mcycle_step #(.WIDTH(WIDTH)) step (
    .accIn   (acc),
    .operand (operand),
    .isDiv   (isDiv),
    .accOut  (stepAcc),
    .qBit    (qBit)
  );

  always_comb begin
    opIn    = mcycle_op_e'(bus.MCycleOp);
    loadDiv = (opIn == MC_DIVU) || (opIn == MC_DIV);
    sign1   = ((opIn == MC_MUL) || (opIn == MC_DIV)) && bus.Operand1[WIDTH-1];
    sign2   = ((opIn == MC_MUL) || (opIn == MC_DIV)) && bus.Operand2[WIDTH-1];
    mag1    = sign1 ? -bus.Operand1 : bus.Operand1;
    mag2    = sign2 ? -bus.Operand2 : bus.Operand2;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) state <= MC_IDLE;
    else         state <= stateNext;
  end

  // Busy rises combinationally with Start so the requester stalls at once.
  always_comb begin
    stateNext = state;
    load      = 1'b0;
    lastIter  = 1'b0;
    bus.Busy  = 1'b0;
    case (state)
      MC_IDLE: begin
        if (bus.Start) begin
          load      = 1'b1;
          bus.Busy  = 1'b1;
          stateNext = MC_COMPUTE;
        end
      end
      MC_COMPUTE: begin
        bus.Busy = 1'b1;
        if (count == LAST) begin
          lastIter  = 1'b1;
          stateNext = MC_IDLE;
        end
      end
      default: stateNext = MC_IDLE;
    endcase
  end

  // A product is negated as one double-width value; quotient and remainder
  // each carry their own sign.
  always_comb begin
    iterAcc = isDiv ? {stepAcc[2*WIDTH-1:1], qBit} : stepAcc;
    prod    = negMain ? -iterAcc : iterAcc;
    quot    = negMain ? -iterAcc[WIDTH-1:0] : iterAcc[WIDTH-1:0];
    rem     = negRem ? -iterAcc[2*WIDTH-1:WIDTH] : iterAcc[2*WIDTH-1:WIDTH];
    res1    = isDiv ? quot : prod[WIDTH-1:0];
    res2    = isDiv ? rem : prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      count       <= '0;
      acc         <= '0;
      operand     <= '0;
      isDiv       <= 1'b0;
      negMain     <= 1'b0;
      negRem      <= 1'b0;
      bus.Result1 <= '0;
      bus.Result2 <= '0;
      bus.Done    <= 1'b0;
    end else begin
      bus.Done <= lastIter;
      if (load) begin
        count   <= '0;
        isDiv   <= loadDiv;
        negMain <= sign1 ^ sign2;
        negRem  <= sign1;
        operand <= loadDiv ? mag2 : mag1;
        acc     <= {{WIDTH{1'b0}}, (loadDiv ? mag1 : mag2)};
      end else if (state == MC_COMPUTE) begin
        count <= count + 1'b1;
        acc   <= iterAcc;
        if (lastIter) begin
          bus.Result1 <= res1;
          bus.Result2 <= res2;
        end
      end
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed checks of mcycle_unit: arithmetic results, latency, reset abort,
// ignored mid-compute requests and back-to-back starts.
module tb_mcycle_unit;
  import mcycle_pkg::*;

  logic CLK = 1'b0;
  logic RESETn;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   busyCnt;

  mcycle_if #(.WIDTH(MC_WIDTH)) bus ();

  mcycle_unit #(.WIDTH(MC_WIDTH)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
  endtask

  // Cycle 0 is the current one; returns the index of the Done cycle or -1.
  task automatic runToDone(input bit holdStart, output int cycles, output int busyCycles);
    cycles     = -1;
    busyCycles = 0;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (bus.Busy) busyCycles++;
      if (bus.Done) begin
        cycles = i;
        break;
      end
      @(negedge CLK);
      if (!holdStart) bus.Start = 1'b0;
    end
  endtask

  task automatic runOperation(input string tag, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp1, input logic [31:0] exp2);
    applyStimulus(op, a, b);
    runToDone(1'b0, lat, busyCnt);
    checkOutput({tag, ".latency"}, lat, 33);
    checkOutput({tag, ".busyCycles"}, busyCnt, 33);
    checkOutput({tag, ".Result1"}, bus.Result1, exp1);
    checkOutput({tag, ".Result2"}, bus.Result2, exp2);
    @(negedge CLK);
    #1;
    checkOutput({tag, ".doneOnce"}, bus.Done, 1'b0);
  endtask

  initial begin
    RESETn       = 1'b0;
    bus.Start    = 1'b0;
    bus.MCycleOp = 2'b00;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    #1;
    checkOutput("reset.Result1", bus.Result1, 0);
    checkOutput("reset.Result2", bus.Result2, 0);
    checkOutput("reset.Done", bus.Done, 0);
    checkOutput("reset.Busy", bus.Busy, 0);

    runOperation("mulu.max", MC_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
    runOperation("mul.neg3x7", MC_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
    runOperation("div.neg7by2", MC_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    runOperation("divu.100by7", MC_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
    runOperation("divu.byZero", MC_DIVU, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);
    runOperation("div.minByNeg1", MC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);

    // Reset around iteration 10 of a multiply, then a fresh request.
    applyStimulus(MC_MULU, 32'd5, 32'd6);
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (9) @(negedge CLK);
    RESETn = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    #1;
    checkOutput("abort.Result1", bus.Result1, 0);
    checkOutput("abort.Result2", bus.Result2, 0);
    checkOutput("abort.Done", bus.Done, 0);
    checkOutput("abort.Busy", bus.Busy, 0);
    applyStimulus(MC_MULU, 32'h0001_0000, 32'h0001_0000);
    runToDone(1'b0, lat, busyCnt);
    checkOutput("abort.newLatency", lat, 33);
    checkOutput("abort.newResult1", bus.Result1, 32'h0);
    checkOutput("abort.newResult2", bus.Result2, 32'h1);

    // A second Start with different operands during COMPUTE is ignored.
    applyStimulus(MC_DIVU, 32'd100, 32'd7);
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (5) @(negedge CLK);
    bus.Start    = 1'b1;
    bus.MCycleOp = MC_MULU;
    bus.Operand1 = 32'd999;
    bus.Operand2 = 32'd3;
    @(negedge CLK);
    bus.Start = 1'b0;
    runToDone(1'b0, lat, busyCnt);
    checkOutput("midStart.latency", lat, 26);
    checkOutput("midStart.Result1", bus.Result1, 32'd14);
    checkOutput("midStart.Result2", bus.Result2, 32'd2);
    @(negedge CLK);
    #1;
    checkOutput("midStart.idleBusy", bus.Busy, 0);
    checkOutput("midStart.idleDone", bus.Done, 0);

    // Start held through Done: next operation loads on the Done edge.
    applyStimulus(MC_MULU, 32'd3, 32'd5);
    runToDone(1'b1, lat, busyCnt);
    checkOutput("b2b.firstLatency", lat, 33);
    checkOutput("b2b.firstBusyCycles", busyCnt, 34);
    checkOutput("b2b.busyInDone", bus.Busy, 1);
    checkOutput("b2b.firstResult1", bus.Result1, 32'd15);
    bus.Operand1 = 32'd7;
    bus.Operand2 = 32'd6;
    @(negedge CLK);
    bus.Start = 1'b0;
    runToDone(1'b0, lat, busyCnt);
    checkOutput("b2b.secondLatency", lat, 32);
    checkOutput("b2b.secondResult1", bus.Result1, 32'd42);
    checkOutput("b2b.secondResult2", bus.Result2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
